// File: rtl/tlul_pkg.sv
// TL-UL channel structs and field widths shared by hosts, devices and fabric.
// Latency: n/a (type definitions only).
// Backpressure: n/a; a_ready lives in d2h and d_ready lives in h2d.
package tlul_pkg;

  localparam int TL_AW   = 32;
  localparam int TL_DW   = 32;
  localparam int TL_AIW  = 8;
  localparam int TL_DIW  = 1;
  localparam int TL_SZW  = 2;
  localparam int TL_DBW  = TL_DW / 8;

  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_host_arb_cnt.sv
// Per-host outstanding-request counter with a limit flag.
// Latency: count and full flag update one cycle after the handshake.
// Backpressure: full=1 tells the arbiter to stop granting this host.
module tlul_host_arb_cnt #(
  parameter int MaxOutstanding = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc,
  input  logic dec,
  output logic full
);

  localparam int CntW = $clog2(MaxOutstanding + 1);

  logic [CntW-1:0] cnt_q;

  // Count A beats up and D beats down; a lone D at zero is ignored.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (inc && !dec) begin
      cnt_q <= cnt_q + CntW'(1);
    end else if (!inc && dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign full = (cnt_q == CntW'(MaxOutstanding));

endmodule

// File: rtl/tlul_host_arb.sv
// N-host to 1-device TL-UL arbiter, round-robin or fixed priority (TLUL_HOST_ARB_FIXED_PRIO_EN).
// Latency: A and D paths are combinational (zero cycle); grant state updates on the clock.
// Backpressure: a stalled grant is locked until accepted; hosts at MaxOutstanding are not granted.
module tlul_host_arb
  import tlul_pkg::*;
#(
  parameter int NumHosts       = 4,
  parameter int MaxOutstanding = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  tl_h2d_t [NumHosts-1:0]   tl_h_i,
  output tl_d2h_t [NumHosts-1:0]   tl_h_o,
  output tl_h2d_t                  tl_d_o,
  input  tl_d2h_t                  tl_d_i
);

  localparam int IdxW = $clog2(NumHosts);

  logic [NumHosts-1:0] full;
  logic [NumHosts-1:0] elig;
  logic [NumHosts-1:0] a_hs;
  logic [NumHosts-1:0] d_hs;
  logic [IdxW-1:0]     gnt;
  logic                gnt_vld;
  logic                a_fire;
  logic                lock_q;
  logic                lock_d;
  logic [IdxW-1:0]     lock_host_q;
  logic [IdxW-1:0]     d_idx;
  logic                d_in_range;
`ifndef TLUL_HOST_ARB_FIXED_PRIO_EN
  logic [IdxW-1:0]     ptr_q;
`endif

  // A host may compete when it requests and still has outstanding budget.
  always_comb begin
    elig = '0;
    for (int h = 0; h < NumHosts; h++) begin
      elig[h] = tl_h_i[h].a_valid & ~full[h];
    end
  end

  // Grant selection: a locked grant wins; otherwise the chosen policy picks.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    if (lock_q) begin
      gnt     = lock_host_q;
      gnt_vld = tl_h_i[lock_host_q].a_valid;
    end else begin
`ifdef TLUL_HOST_ARB_FIXED_PRIO_EN
      // Scan downward so the lowest eligible index is assigned last.
      for (int i = NumHosts - 1; i >= 0; i--) begin
        if (elig[i]) begin
          gnt     = IdxW'(i);
          gnt_vld = 1'b1;
        end
      end
`else
      // Scan the farthest candidate first so the nearest one after ptr wins.
      for (int k = NumHosts; k >= 1; k--) begin
        if (elig[(int'(ptr_q) + k) % NumHosts]) begin
          gnt     = IdxW'((int'(ptr_q) + k) % NumHosts);
          gnt_vld = 1'b1;
        end
      end
`endif
    end
  end

  assign a_fire = gnt_vld & tl_d_i.a_ready & ~rst_i;
  assign lock_d = gnt_vld & ~tl_d_i.a_ready;

  // Hold the grant on a host whose request the device has not yet taken.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q      <= 1'b0;
      lock_host_q <= '0;
    end else begin
      lock_q <= lock_d;
      if (lock_d) begin
        lock_host_q <= gnt;
      end
    end
  end

`ifndef TLUL_HOST_ARB_FIXED_PRIO_EN
  // Remember the last host whose A beat was accepted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= IdxW'(NumHosts - 1);
    end else if (a_fire) begin
      ptr_q <= gnt;
    end
  end
`endif

  assign d_idx      = tl_d_i.d_source[IdxW-1:0];
  assign d_in_range = (int'(d_idx) < NumHosts);

  // Merged device request: granted host's fields with its index in the low source bits.
  always_comb begin
    tl_d_o          = tl_h_i[gnt];
    tl_d_o.a_source = {tl_h_i[gnt].a_source[TL_AIW-1:IdxW], gnt};
    tl_d_o.a_valid  = gnt_vld & ~rst_i;
    tl_d_o.d_ready  = ~rst_i & (d_in_range ? tl_h_i[d_idx].d_ready : 1'b1);
  end

  // Host responses: D fields broadcast, valids and a_ready steered to one host.
  always_comb begin
    for (int h = 0; h < NumHosts; h++) begin
      tl_h_o[h]          = tl_d_i;
      tl_h_o[h].d_source = tl_d_i.d_source >> IdxW;
      tl_h_o[h].d_valid  = ~rst_i & tl_d_i.d_valid & d_in_range & (d_idx == IdxW'(h));
      tl_h_o[h].a_ready  = ~rst_i & gnt_vld & (gnt == IdxW'(h)) & tl_d_i.a_ready;
      a_hs[h]            = a_fire & (gnt == IdxW'(h));
      d_hs[h]            = ~rst_i & tl_d_i.d_valid & d_in_range & (d_idx == IdxW'(h))
                           & tl_h_i[h].d_ready;
    end
  end

  for (genvar h = 0; h < NumHosts; h++) begin : g_cnt
    tlul_host_arb_cnt #(
      .MaxOutstanding(MaxOutstanding)
    ) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc   (a_hs[h]),
      .dec   (d_hs[h]),
      .full  (full[h])
    );
  end

endmodule

// File: tb/tb_tlul_host_arb.sv
// Randomized and directed bench for tlul_host_arb with a queue-based scoreboard.
// Latency: expectations are for the same cycle the stimulus is applied.
// Backpressure: device a_ready and host d_ready are driven randomly or per scenario.
module tb_tlul_host_arb;
  import tlul_pkg::*;

  localparam int NH = 4;
  localparam int MO = 4;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  tl_h2d_t [NH-1:0] tl_h_i;
  tl_d2h_t [NH-1:0] tl_h_o;
  tl_h2d_t          tl_d_o;
  tl_d2h_t          tl_d_i;

  always #5 clk = ~clk;

  tlul_host_arb #(.NumHosts(NH), .MaxOutstanding(MO)) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .tl_h_i (tl_h_i),
    .tl_h_o (tl_h_o),
    .tl_d_o (tl_d_o),
    .tl_d_i (tl_d_i)
  );

  typedef struct {
    bit          a_valid;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_ready;
    logic [3:0]  d_valid;
    int          d_host;
    logic [7:0]  d_source;
    logic [31:0] d_data;
    bit          d_ready;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference state: what each host has in flight and who went last.
  int          outst[NH];
  int          last_g;
  int          lock_h;
  bit          pend[NH];
  logic [31:0] addr[NH];
  logic [7:0]  asrc[NH];

  // Observations for the directed scenarios.
  int         obs_g;
  logic [3:0] obs_ar;
  logic [3:0] obs_dv;
  logic [7:0] obs_ds1;
  bit         obs_dr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int model_grant();
    if (lock_h >= 0) return lock_h;
`ifdef TLUL_HOST_ARB_FIXED_PRIO_EN
    for (int h = 0; h < NH; h++) if (pend[h] && outst[h] < MO) return h;
`else
    for (int k = 1; k <= NH; k++) begin
      int h;
      h = (last_g + k) % NH;
      if (pend[h] && outst[h] < MO) return h;
    end
`endif
    return -1;
  endfunction

  task automatic step(input bit rst, input logic [3:0] want, input bit ar,
                      input bit dv, input logic [7:0] dsrc, input logic [3:0] hdr);
    exp_t e;
    int g, di, ai;
    @(negedge clk);
    rst_i = rst;
    for (int h = 0; h < NH; h++) begin
      if (rst) begin
        pend[h] = 1'b0;
        addr[h] = $urandom;
        asrc[h] = 8'($urandom);
      end else if (want[h] && !pend[h]) begin
        pend[h] = 1'b1;
        addr[h] = $urandom;
        asrc[h] = 8'($urandom);
      end
      tl_h_i[h]           = '0;
      tl_h_i[h].a_valid   = rst ? want[h] : pend[h];
      tl_h_i[h].a_address = addr[h];
      tl_h_i[h].a_source  = asrc[h];
      tl_h_i[h].a_data    = ~addr[h];
      tl_h_i[h].d_ready   = hdr[h];
    end
    tl_d_i          = '0;
    tl_d_i.a_ready  = ar;
    tl_d_i.d_valid  = dv;
    tl_d_i.d_source = dsrc;
    tl_d_i.d_data   = $urandom;

    g  = rst ? -1 : model_grant();
    di = int'(dsrc) % NH;
    e.a_valid   = (g >= 0);
    e.a_source  = (g >= 0) ? {asrc[g][7:2], 2'(g)} : 8'h00;
    e.a_address = (g >= 0) ? addr[g] : 32'h0;
    e.a_ready   = '0;
    if (g >= 0) e.a_ready[g] = ar;
    e.d_valid   = '0;
    if (!rst) e.d_valid[di] = dv;
    e.d_host    = di;
    e.d_source  = dsrc / NH;
    e.d_data    = tl_d_i.d_data;
    e.d_ready   = rst ? 1'b0 : hdr[di];
    sb.push_back(e);

    #3;
    obs_g   = tl_d_o.a_valid ? int'(tl_d_o.a_source[1:0]) : -1;
    obs_dr  = tl_d_o.d_ready;
    obs_ds1 = tl_h_o[1].d_source;
    for (int h = 0; h < NH; h++) begin
      obs_ar[h] = tl_h_o[h].a_ready;
      obs_dv[h] = tl_h_o[h].d_valid;
    end

    // Advance the reference to the state after this clock edge.
    if (rst) begin
      for (int h = 0; h < NH; h++) outst[h] = 0;
      last_g = NH - 1;
      lock_h = -1;
    end else begin
      ai = (g >= 0 && ar) ? g : -1;
      if (!(dv && hdr[di])) di = -1;
      for (int h = 0; h < NH; h++) begin
        if (ai == h && di != h) outst[h]++;
        else if (di == h && ai != h && outst[h] > 0) outst[h]--;
      end
      if (ai >= 0) begin
        last_g   = ai;
        pend[ai] = 1'b0;
        lock_h   = -1;
      end else begin
        lock_h = g;
      end
    end
  endtask

  // Monitor: compare DUT outputs against the oldest expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("a_valid", tl_d_o.a_valid, e.a_valid);
        if (e.a_valid) begin
          check("a_source", tl_d_o.a_source, e.a_source);
          check("a_address", tl_d_o.a_address, e.a_address);
        end
        for (int h = 0; h < NH; h++) begin
          check("a_ready", tl_h_o[h].a_ready, e.a_ready[h]);
          check("d_valid", tl_h_o[h].d_valid, e.d_valid[h]);
        end
        check("d_source", tl_h_o[e.d_host].d_source, e.d_source);
        check("d_data", tl_h_o[e.d_host].d_data, e.d_data);
        check("d_ready", tl_d_o.d_ready, e.d_ready);
      end
    end
  end

  initial begin
    tl_h_i = '0;
    tl_d_i = '0;
    for (int h = 0; h < NH; h++) begin
      outst[h] = 0;
      pend[h]  = 1'b0;
      addr[h]  = '0;
      asrc[h]  = '0;
    end
    last_g = NH - 1;
    lock_h = -1;

    // Reset: everything quiet even with requests and a response present.
    step(1, 4'hF, 1, 1, 8'h01, 4'hF);
    check("rst_a_valid", 64'(obs_g), 64'(-1));
    check("rst_a_ready", obs_ar, 4'h0);
    check("rst_d_valid", obs_dv, 4'h0);
    check("rst_d_ready", obs_dr, 1'b0);

    // Rotation across all hosts (or fixed priority with hosts 0 and 3).
`ifdef TLUL_HOST_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 6; i++) begin
      step(0, 4'b1001, 1, 1, 8'h00, 4'hF);
      check("fixed_gnt", 64'(obs_g), 64'(0));
    end
`else
    step(0, 4'hF, 1, 1, 8'h00, 4'hF); check("rr_gnt_a", 64'(obs_g), 64'(0));
    step(0, 4'hF, 1, 1, 8'h00, 4'hF); check("rr_gnt_b", 64'(obs_g), 64'(1));
    step(0, 4'hF, 1, 1, 8'h00, 4'hF); check("rr_gnt_c", 64'(obs_g), 64'(2));
    step(0, 4'hF, 1, 1, 8'h00, 4'hF); check("rr_gnt_d", 64'(obs_g), 64'(3));
    step(0, 4'hF, 1, 1, 8'h00, 4'hF); check("rr_gnt_e", 64'(obs_g), 64'(0));
`endif

    // Lock: host 2 stalled three cycles while host 1 waits.
    step(1, 4'h0, 0, 0, 8'h00, 4'h0);
    step(0, 4'b0100, 0, 0, 8'h00, 4'h0); check("lock_a", 64'(obs_g), 64'(2));
    step(0, 4'b0110, 0, 0, 8'h00, 4'h0); check("lock_b", 64'(obs_g), 64'(2));
    step(0, 4'b0110, 0, 0, 8'h00, 4'h0); check("lock_c", 64'(obs_g), 64'(2));
    step(0, 4'b0110, 1, 0, 8'h00, 4'h0); check("lock_hs", 64'(obs_g), 64'(2));
    step(0, 4'b0011, 1, 0, 8'h00, 4'h0); check("after_lock_a", 64'(obs_g), 64'(0));
`ifdef TLUL_HOST_ARB_FIXED_PRIO_EN
    step(0, 4'b0011, 1, 0, 8'h00, 4'h0); check("after_lock_b", 64'(obs_g), 64'(0));
`else
    step(0, 4'b0011, 1, 0, 8'h00, 4'h0); check("after_lock_b", 64'(obs_g), 64'(1));
`endif

    // Outstanding limit on host 1, reopened by one D beat.
    step(1, 4'h0, 0, 0, 8'h00, 4'h0);
    for (int i = 0; i < MO; i++) begin
      step(0, 4'b0010, 1, 0, 8'h00, 4'h0);
      check("limit_fill", 64'(obs_g), 64'(1));
    end
    step(0, 4'b0010, 1, 0, 8'h00, 4'h0);
    check("limit_block", 64'(obs_g), 64'(-1));
    check("limit_ar", obs_ar, 4'h0);
    step(0, 4'b0010, 1, 1, 8'h05, 4'b0010);
    check("limit_d_cycle", 64'(obs_g), 64'(-1));
    step(0, 4'b0010, 1, 0, 8'h00, 4'h0);
    check("limit_reopen", 64'(obs_g), 64'(1));

    // D routing with source 0x0D.
    step(0, 4'h0, 1, 1, 8'h0D, 4'hF);
    check("d_route_valid", obs_dv, 4'b0010);
    check("d_route_src", obs_ds1, 8'h03);

    // Same-cycle A and D on host 0 at count 2 keeps the count at 2.
    step(1, 4'h0, 0, 0, 8'h00, 4'h0);
    step(0, 4'b0001, 1, 0, 8'h00, 4'h0); check("same_a", 64'(obs_g), 64'(0));
    step(0, 4'b0001, 1, 0, 8'h00, 4'h0); check("same_b", 64'(obs_g), 64'(0));
    step(0, 4'b0001, 1, 1, 8'h00, 4'b0001); check("same_ad", 64'(obs_g), 64'(0));
    step(0, 4'b0001, 1, 0, 8'h00, 4'h0); check("same_c", 64'(obs_g), 64'(0));
    step(0, 4'b0001, 1, 0, 8'h00, 4'h0); check("same_d", 64'(obs_g), 64'(0));
    step(0, 4'b0001, 1, 0, 8'h00, 4'h0); check("same_full", 64'(obs_g), 64'(-1));

    // Reset while host 2 holds the lock; host 0 wins afterwards.
    step(0, 4'b0100, 0, 0, 8'h00, 4'h0); check("mid_lock", 64'(obs_g), 64'(2));
    step(1, 4'b0100, 0, 0, 8'h00, 4'h0);
    step(0, 4'b0101, 1, 0, 8'h00, 4'h0); check("post_rst_gnt", 64'(obs_g), 64'(0));

    // Random traffic checked by the scoreboard.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0), 4'($urandom), ($urandom_range(0, 3) != 0),
           1'($urandom), 8'($urandom), 4'($urandom));
    end

    @(negedge clk);
    #5;
    check("sb_drain", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
